turbo_frame_serializer: RTL and testbench
=========================================

# turbo_frame_serializer

Downstream stage of the 8-bit turbo encoder. Accepts one systematic byte plus its 8-bit parity word ({parity1, parity2}) per transaction and emits a serial frame. The frame is a sync word, the systematic bits, the full or punctured parity bits, and one even-parity check bit. It provides valid/ready flow control on both sides and feeds the line/modulator interface.

## Interface
Parameters:
- SYNC_WORD, 8'hB8: frame header, sent MSB first.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sys_data/parity_word valid.
- in_ready  out  1  block can accept a frame this cycle.
- sys_data  in  8  systematic byte (encoder ui_in).
- parity_word  in  8  encoder output: [7:4]=parity1, [3:0]=parity2.
- puncture_en  in  1  sampled at accept: 1 = punctured parity (4 bits), 0 = full (8 bits).
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out is valid.
- ser_ready  in  1  downstream consumes ser_out when ser_valid && ser_ready.
- frame_start  out  1  high while the first sync bit is presented.
- frame_end  out  1  high while the check bit is presented.

## Operation
- States: IDLE, SYNC, SYS, PAR, CHK. A 3-bit bit index counts within each state.
- Accept = in_valid && in_ready. On accept, latch sys_data, parity_word and puncture_en, clear the running checksum, and enter SYNC with index 7.
- in_ready = (state==IDLE) || (state==CHK && ser_ready). This is combinational and allows back-to-back frames with no idle bit.
- A bit advances only on ser_valid && ser_ready. While stalled, ser_out, state and index hold.
- SYNC: sends SYNC_WORD[7] down to [0], then goes to SYS.
- SYS: sends sys_data[7] down to [0], then goes to PAR.
- PAR, full mode: sends parity_word[7] down to [0].
- PAR, punctured mode: sends parity_word bits 7, 2, 5, 0 in that order (p1[3], p2[2], p1[1], p2[0]).
- After PAR, go to CHK.
- CHK: sends the XOR of all transmitted SYS and PAR bits (even parity over the payload). Sync bits are excluded.
- Leaving CHK:
  - On the transfer with accept, go to SYNC for the new frame.
  - On the transfer without accept, go to IDLE.
- Frame length is 25 bits in full mode and 21 bits in punctured mode.
- ser_valid = (state != IDLE).
- frame_start = (state==SYNC && index==7).
- frame_end = (state==CHK).

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE; latched data and checksum = 0.
  - ser_out=0, ser_valid=0, frame_start=0, frame_end=0, in_ready=1.
- Reset deassertion takes effect at the next rising edge. A frame in progress is discarded with no partial continuation.
- Latency: accept at edge N. The first sync bit is on ser_out with ser_valid=1 after edge N, i.e. in cycle N+1.
- With ser_ready tied high, one bit is sent per cycle. The check bit is in cycle N+25 (full) or N+21 (punctured).
- Inputs other than the handshake are ignored outside accept. puncture_en changing mid-frame has no effect.
- in_valid while busy (not in CHK with ser_ready) is held off by in_ready=0. The upstream source must hold its data.
- ser_ready low during CHK keeps in_ready low, so no accept occurs.
- Checksum update and bit shift happen on the same transfer edge.

## Structure
- Shared package turbo_pkg:
  - state enum (IDLE, SYNC, SYS, PAR, CHK).
  - SYNC_WORD default.
  - FULL_PAR_BITS=8, PUNC_PAR_BITS=4.
  - puncture index constants {7,2,5,0}.
- One sub-module is natural: turbo_par_select. It is combinational and maps (parity_word, puncture_en, index) to the parity bit and last-bit flag.
- All remaining logic is a single FSM plus datapath.

## Test plan
- Reset: assert rst_n=0 mid-frame → all outputs at reset values immediately. After release, in_ready=1 and ser_valid=0.
- Full mode: sys=8'hA5, parity=8'h3C, ser_ready=1.
  - Required 25-bit stream: 10111000 10100101 00111100 0.
  - frame_start on bit 1, frame_end on bit 25.
- Punctured mode: sys=8'h01, parity=8'h3C.
  - Required stream: 10111000 00000001 0110 1 (21 bits).
- Backpressure: full frame with ser_ready toggled pseudo-randomly → identical bit sequence. ser_out is stable while ser_ready=0.
- Back-to-back: in_valid held high with frames A5/3C and 01/00 (full) → the new frame_start occurs in the cycle immediately after the check bit, with no gap.
- Hold-off: in_valid pulsed during SYS → no accept and in_ready=0. The frame completes unaltered.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo frame serializer.
package turbo_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    SYS  = 3'd2,
    PAR  = 3'd3,
    CHK  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hB8;

  localparam int FULL_PAR_BITS = 8;
  localparam int PUNC_PAR_BITS = 4;

  // Punctured parity order p1[3], p2[2], p1[1], p2[0]; element [0] goes first.
  localparam logic [3:0][2:0] PUNC_IDX = {3'd0, 3'd5, 3'd2, 3'd7};

endpackage

// File: rtl/turbo_par_select.sv
// Picks the parity bit for the current PAR index and flags the last one.
// The PAR index always starts at 7 and counts down; in punctured mode the
// distance from 7 selects an entry of the puncture table.
module turbo_par_select
  import turbo_pkg::*;
(
  input  logic [7:0] par_word,
  input  logic       punc,
  input  logic [2:0] idx,
  output logic       par_bit,
  output logic       last
);

  logic [2:0] pos;

  // Full mode walks the word MSB first; punctured mode walks the table.
  always_comb begin
    pos     = 3'd7 - idx;
    par_bit = par_word[idx];
    last    = (idx == 3'(8 - FULL_PAR_BITS));
    if (punc) begin
      par_bit = par_word[PUNC_IDX[pos[1:0]]];
      last    = (idx == 3'(8 - PUNC_PAR_BITS));
    end
  end

endmodule

// File: rtl/turbo_frame_serializer.sv
// Serializes one systematic byte plus parity word into a framed bit stream:
// sync word, systematic bits, full or punctured parity, even-parity check bit.
module turbo_frame_serializer
  import turbo_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] sys_data,
  input  logic [7:0] parity_word,
  input  logic       puncture_en,
  output logic       ser_out,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       frame_start,
  output logic       frame_end
);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sys_q, sys_d;
  logic [7:0] par_q, par_d;
  logic       punc_q, punc_d;
  logic       chk_q, chk_d;

  logic       par_bit, par_last;
  logic       xfer, accept;

  turbo_par_select u_par_select (
    .par_word (par_q),
    .punc     (punc_q),
    .idx      (idx_q),
    .par_bit  (par_bit),
    .last     (par_last)
  );

  assign xfer   = ser_valid && ser_ready;
  assign accept = in_valid && in_ready;

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      sys_q   <= 8'd0;
      par_q   <= 8'd0;
      punc_q  <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sys_q   <= sys_d;
      par_q   <= par_d;
      punc_q  <= punc_d;
      chk_q   <= chk_d;
    end
  end

  // Next state: bits advance only on a downstream transfer; a new frame is
  // loaded from IDLE or on the check-bit transfer for back-to-back frames.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sys_d   = sys_q;
    par_d   = par_q;
    punc_d  = punc_q;
    chk_d   = chk_q;
    case (state_q)
      IDLE: ;
      SYNC: if (xfer) begin
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          state_d = SYS;
          idx_d   = 3'd7;
        end
      end
      SYS: if (xfer) begin
        chk_d = chk_q ^ sys_q[idx_q];
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          state_d = PAR;
          idx_d   = 3'd7;
        end
      end
      PAR: if (xfer) begin
        chk_d = chk_q ^ par_bit;
        idx_d = idx_q - 3'd1;
        if (par_last) begin
          state_d = CHK;
          idx_d   = 3'd0;
        end
      end
      CHK: if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // in_ready is only high in IDLE or on the CHK transfer, so accept
    // overrides whatever the case above chose.
    if (accept) begin
      state_d = SYNC;
      idx_d   = 3'd7;
      sys_d   = sys_data;
      par_d   = parity_word;
      punc_d  = puncture_en;
      chk_d   = 1'b0;
    end
  end

  // Outputs decoded from state and index; ser_out holds while stalled
  // because state and index hold.
  always_comb begin
    in_ready    = (state_q == IDLE) || (state_q == CHK && ser_ready);
    ser_valid   = (state_q != IDLE);
    frame_start = (state_q == SYNC) && (idx_q == 3'd7);
    frame_end   = (state_q == CHK);
    case (state_q)
      SYNC:    ser_out = SYNC_WORD[idx_q];
      SYS:     ser_out = sys_q[idx_q];
      PAR:     ser_out = par_bit;
      CHK:     ser_out = chk_q;
      default: ser_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_turbo_frame_serializer.sv
// Bench for turbo_frame_serializer: table of frames with hand-derived bit
// streams, scoreboard queue of expected bits, plus reset, backpressure,
// back-to-back and hold-off sequences.
module tb_turbo_frame_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] sys_data, parity_word;
  logic       puncture_en;
  logic       ser_out, ser_valid, ser_ready;
  logic       frame_start, frame_end;

  turbo_frame_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sys_data    (sys_data),
    .parity_word (parity_word),
    .puncture_en (puncture_en),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .ser_ready   (ser_ready),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sys;
    logic [7:0]  par;
    logic        punc;
    int          len;
    logic [24:0] exp;   // right-aligned, first bit at exp[len-1]
  } vec_t;

  typedef struct {
    logic b;
    logic s;
    logic e;
  } exp_t;

  vec_t vt[7];
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int end_cyc = 0;
  int last_gap = 0;
  bit mon_en = 1'b0;
  bit bp_en  = 1'b0;
  bit prev_stall = 1'b0;
  logic prev_bit = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pseudo-random downstream backpressure.
  always @(posedge clk) if (bp_en) begin
    #1 ser_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard consumer: pop one expected bit per transfer; also check that
  // a stalled bit does not change.
  always @(negedge clk) if (mon_en) begin
    if (prev_stall && ser_valid) check("stall_hold", 32'(ser_out), 32'(prev_bit));
    if (ser_valid && ser_ready) begin
      if (q.size() == 0) begin
        check("unexpected_bit", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ser_out", 32'(ser_out), 32'(e.b));
        check("frame_start", 32'(frame_start), 32'(e.s));
        check("frame_end", 32'(frame_end), 32'(e.e));
        if (e.s) last_gap = cyc - end_cyc;
        if (e.e) end_cyc = cyc;
      end
    end
    prev_stall = ser_valid && !ser_ready;
    prev_bit   = ser_out;
  end

  task automatic push_frame(input int k);
    for (int i = vt[k].len - 1; i >= 0; i--) begin
      exp_t e;
      e.b = vt[k].exp[i];
      e.s = (i == vt[k].len - 1);
      e.e = (i == 0);
      q.push_back(e);
    end
  endtask

  // Present frame k and wait for accept; hold keeps in_valid high afterwards.
  task automatic send_vec(input int k, input bit hold);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid    = 1'b1;
    sys_data    = vt[k].sys;
    parity_word = vt[k].par;
    puncture_en = vt[k].punc;
    #1;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) begin
      check("accept_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
    end else begin
      push_frame(k);
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
      check("first_bit_latency", 32'({ser_valid, frame_start}), 32'(2'b11));
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      if (q.size() == 0 && !ser_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("frame_done_timeout", 32'(0), 32'(1));
      q.delete();
    end
  endtask

  task automatic check_reset_outs(input string name);
    check(name, 32'({ser_out, ser_valid, frame_start, frame_end, in_ready}), 32'(5'b00001));
  endtask

  initial begin
    vt[0] = '{8'hA5, 8'h3C, 1'b0, 25, 25'b10111000_10100101_00111100_0};
    vt[1] = '{8'h01, 8'h3C, 1'b1, 21, 25'b0000_10111000_00000001_0110_1};
    vt[2] = '{8'hFF, 8'hFF, 1'b0, 25, 25'b10111000_11111111_11111111_0};
    vt[3] = '{8'h80, 8'h81, 1'b1, 21, 25'b0000_10111000_10000000_1001_1};
    vt[4] = '{8'h00, 8'h00, 1'b0, 25, 25'b10111000_00000000_00000000_0};
    vt[5] = '{8'h5A, 8'hC3, 1'b1, 21, 25'b0000_10111000_01011010_1001_0};
    vt[6] = '{8'h01, 8'h00, 1'b0, 25, 25'b10111000_00000001_00000000_1};

    rst_n = 1'b0; in_valid = 1'b0; sys_data = 8'h00; parity_word = 8'h00;
    puncture_en = 1'b0; ser_ready = 1'b1;
    #2 check_reset_outs("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;

    // Table frames with ser_ready tied high.
    for (int k = 0; k < 7; k++) begin
      send_vec(k, 1'b0);
      wait_done();
      check("idle_in_ready", 32'(in_ready), 32'(1));
    end

    // Backpressure: same streams under random ser_ready.
    bp_en = 1'b1;
    send_vec(0, 1'b0); wait_done();
    send_vec(3, 1'b0); wait_done();
    bp_en = 1'b0;
    @(posedge clk); #1 ser_ready = 1'b1;

    // Back-to-back: second frame_start directly after the check bit.
    send_vec(0, 1'b1);
    send_vec(6, 1'b0);
    wait_done();
    check("b2b_gap", 32'(last_gap), 32'(1));

    // Hold-off: in_valid pulsed during SYS must not be accepted.
    send_vec(0, 1'b0);
    repeat (10) @(negedge clk);
    in_valid = 1'b1; sys_data = 8'hFF; parity_word = 8'hFF; puncture_en = 1'b1;
    #1 check("holdoff_in_ready", 32'(in_ready), 32'(0));
    @(negedge clk); #1 check("holdoff_in_ready2", 32'(in_ready), 32'(0));
    in_valid = 1'b0;
    wait_done();

    // Reset mid-frame: outputs return to reset values immediately.
    send_vec(2, 1'b0);
    repeat (10) @(posedge clk);
    mon_en = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_outs("async_reset_outputs");
    repeat (2) @(posedge clk);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset", 32'({ser_valid, in_ready}), 32'(2'b01));
    mon_en = 1'b1;
    send_vec(1, 1'b0); wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
